// File: rtl/addr_map_rule_pkg.sv
// Shared address-map types for the OBI demux family.
// The rule fields are sized for the widest supported map. Each user slices
// them down to its own ADDR_WIDTH and index width, so one typedef serves
// every instance.
package addr_map_rule_pkg;

    localparam int unsigned RULE_IDX_W  = 32;
    localparam int unsigned RULE_ADDR_W = 64;

    // A rule covers [start_addr, end_addr). The end address is exclusive.
    typedef struct packed {
        logic [RULE_IDX_W-1:0]  idx;
        logic [RULE_ADDR_W-1:0] start_addr;
        logic [RULE_ADDR_W-1:0] end_addr;
    } addr_map_rule_t;

    // Read data returned by the internal error target. Replicate this bit
    // to the local data width.
    localparam logic ERR_RDATA_BIT = 1'b0;

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder. The first matching rule wins.
// Ports:
//   addr_i        address to decode
//   addr_map_i    NUM_RULES rules {idx, start_addr, end_addr}
//   default_idx_i index used when no rule matches and en_default_i=1
//   en_default_i  enable the default index
//   idx_o         decoded index (valid when dec_valid_o=1)
//   dec_valid_o   a rule matched, or the default index applied
module addr_decode
    import addr_map_rule_pkg::*;
#(
    parameter int unsigned NUM_RULES  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 1
) (
    input  logic [ADDR_WIDTH-1:0]                addr_i,
    input  addr_map_rule_t [NUM_RULES-1:0]       addr_map_i,
    input  logic [IDX_WIDTH-1:0]                 default_idx_i,
    input  logic                                 en_default_i,
    output logic [IDX_WIDTH-1:0]                 idx_o,
    output logic                                 dec_valid_o
);

    logic unused_map_bits;
    assign unused_map_bits = ^addr_map_i;

    // Scan from the last rule to the first. A lower-numbered match then
    // overwrites a higher one, so the first rule in the table wins.
    always_comb begin
        idx_o       = '0;
        dec_valid_o = 1'b0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (addr_i >= addr_map_i[i].start_addr[ADDR_WIDTH-1:0] &&
                addr_i <  addr_map_i[i].end_addr[ADDR_WIDTH-1:0]) begin
                idx_o       = addr_map_i[i].idx[IDX_WIDTH-1:0];
                dec_valid_o = 1'b1;
            end
        end
        if (!dec_valid_o && en_default_i) begin
            idx_o       = default_idx_i;
            dec_valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/obi_demux_ot.sv
// OBI 1-to-NSLAVE demultiplexer with outstanding-transaction tracking.
// A request is routed combinationally by address. Responses return in order
// from the slave that took the last accepted request. The demux stalls
// while transactions are outstanding to a different slave, and also when
// MAX_TRANS transactions are in flight. An unmapped address goes to an
// internal error target. That target answers one cycle after each accept
// with m_err_o=1 and zero read data.
// Ports:
//   clk_i, rst_i                         clock, async active-high reset
//   addr_map_i/default_idx_i/en_default_i   address map configuration
//   m_*                                  master side (req/gnt/rvalid/rdata/err)
//   s_*                                  slave side; we/be/addr/wdata are
//                                        broadcast to every slave
module obi_demux_ot
    import addr_map_rule_pkg::*;
#(
    parameter  int unsigned NSLAVE     = 2,
    parameter  int unsigned NUM_RULES  = NSLAVE,
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned MAX_TRANS  = 4,
    localparam int unsigned BeWidth    = DATA_WIDTH / 8,
    localparam int unsigned IdxWidth   = (NSLAVE > 1) ? $clog2(NSLAVE) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  addr_map_rule_t [NUM_RULES-1:0]       addr_map_i,
    input  logic [IdxWidth-1:0]                  default_idx_i,
    input  logic                                 en_default_i,
    input  logic                                 m_req_i,
    input  logic                                 m_we_i,
    input  logic [BeWidth-1:0]                   m_be_i,
    input  logic [ADDR_WIDTH-1:0]                m_addr_i,
    input  logic [DATA_WIDTH-1:0]                m_wdata_i,
    output logic                                 m_gnt_o,
    output logic                                 m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m_rdata_o,
    output logic                                 m_err_o,
    output logic [NSLAVE-1:0]                    s_req_o,
    output logic                                 s_we_o,
    output logic [BeWidth-1:0]                   s_be_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    input  logic [NSLAVE-1:0]                    s_gnt_i,
    input  logic [NSLAVE-1:0]                    s_rvalid_i,
    input  logic [NSLAVE-1:0][DATA_WIDTH-1:0]    s_rdata_i
);

    // Target indices run 0..NSLAVE. Index NSLAVE is the internal error target.
    localparam int unsigned TgtWidth = $clog2(NSLAVE + 1);
    localparam int unsigned CntWidth = $clog2(MAX_TRANS + 1);
    localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NSLAVE);

    logic [IdxWidth-1:0]   dec_idx;
    logic                  dec_valid;
    logic [TgtWidth-1:0]   tgt, last_tgt;
    logic [CntWidth-1:0]   cnt;
    logic [NSLAVE-1:0]     tgt_oh, last_oh;
    logic                  tgt_is_err, last_is_err;
    logic                  stall, accept, rsp_vld_raw, rsp;
    logic                  err_rsp_q;
    logic [DATA_WIDTH-1:0] rdata_sel;

    addr_decode #(
        .NUM_RULES  (NUM_RULES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IdxWidth)
    ) u_addr_decode (
        .addr_i        (m_addr_i),
        .addr_map_i    (addr_map_i),
        .default_idx_i (default_idx_i),
        .en_default_i  (en_default_i),
        .idx_o         (dec_idx),
        .dec_valid_o   (dec_valid)
    );

    assign tgt         = dec_valid ? TgtWidth'(dec_idx) : ErrTgt;
    assign tgt_is_err  = (tgt == ErrTgt);
    assign last_is_err = (last_tgt == ErrTgt);

    // One-hot selects avoid out-of-range indexing when a target is ErrTgt.
    for (genvar i = 0; i < NSLAVE; i++) begin : g_oh
        assign tgt_oh[i]  = (tgt == TgtWidth'(i));
        assign last_oh[i] = (last_tgt == TgtWidth'(i));
    end

    // Responses come back in order only when they all come from one slave.
    // Hold a request to a different target until the pipe drains.
    assign stall = (cnt == CntWidth'(MAX_TRANS)) ||
                   ((cnt != '0) && (tgt != last_tgt));

    assign s_req_o = (rst_i || stall) ? '0 : (tgt_oh & {NSLAVE{m_req_i}});
    assign m_gnt_o = !rst_i && !stall &&
                     (tgt_is_err ? m_req_i : |(s_gnt_i & tgt_oh));
    assign accept  = m_req_i && m_gnt_o;

    assign s_we_o    = m_we_i;
    assign s_be_o    = m_be_i;
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (last_oh[i]) rdata_sel = s_rdata_i[i];
        end
    end

    assign rsp_vld_raw = last_is_err ? err_rsp_q : |(s_rvalid_i & last_oh);
    // A response with nothing outstanding is not counted. This prevents
    // counter underflow.
    assign rsp         = rsp_vld_raw && (cnt != '0);

    assign m_rvalid_o = !rst_i && rsp_vld_raw;
    assign m_err_o    = !rst_i && last_is_err && err_rsp_q;
    assign m_rdata_o  = (rst_i || last_is_err) ? {DATA_WIDTH{ERR_RDATA_BIT}}
                                               : rdata_sel;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            last_tgt  <= '0;
            err_rsp_q <= 1'b0;
        end else begin
            err_rsp_q <= accept && tgt_is_err;
            if (accept) last_tgt <= tgt;
            if (accept && !rsp)      cnt <= cnt + CntWidth'(1);
            else if (!accept && rsp) cnt <= cnt - CntWidth'(1);
        end
    end

    // Protocol checks: no rvalid from a slave we are not waiting on, and no
    // rvalid while nothing is outstanding.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((s_rvalid_i & ~last_oh) == '0)
                else $error("obi_demux_ot: rvalid from non-selected slave");
            assert (!(rsp_vld_raw && cnt == '0))
                else $error("obi_demux_ot: response with no outstanding transaction");
        end
    end

endmodule
